// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// fp_pkg
// Shared state encoding, timeout default and FP32 constants for fpacc_seq.
// Rev 1.0
// ============================================================================
package fp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_GUARD  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_OUTPUT = 3'd4
   } state_t;

   localparam int TIMEOUT_DEFAULT = 64;

   localparam logic [31:0] POS_ONE   = 32'h3F80_0000;
   localparam logic [31:0] POS_TWO   = 32'h4000_0000;
   localparam logic [31:0] POS_THREE = 32'h4040_0000;
   localparam logic [31:0] POS_SIX   = 32'h40C0_0000;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpacc_timer.sv
`default_nettype none
// ============================================================================
// fpacc_timer
// Wait-cycle counter: expired is raised on the TIMEOUT-th enabled cycle.
// Rev 1.0
// ============================================================================
module fpacc_timer
   import fp_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of enabled cycles already elapsed.
   assign expired = enable && !clear && (cnt_q == LIMIT);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fpacc_seq.sv
`default_nettype none
// ============================================================================
// fpacc_seq
// Sequences an external FP32 adder to accumulate operand groups.
// Rev 1.0
// ============================================================================
module fpacc_seq
   import fp_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        add_start,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_sum,
   input  logic        add_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [7:0]  out_count,
   output logic        out_err
);

   state_t      state_q, state_d;
   logic        first_q, first_d;
   logic [31:0] acc_q, acc_d;
   logic [7:0]  count_q, count_d;
   logic        err_q, err_d;
   logic        last_q, last_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        tmr_clear, tmr_enable, tmr_expired;

   fpacc_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   // in_ready is held low while reset is asserted even though state is IDLE.
   assign in_ready  = (state_q == ST_IDLE) && reset;
   assign add_start = (state_q == ST_ISSUE);
   assign add_a     = a_q;
   assign add_b     = b_q;
   assign out_valid = (state_q == ST_OUTPUT);
   assign out_data  = acc_q;
   assign out_count = count_q;
   assign out_err   = err_q;

   always_comb begin
      state_d    = state_q;
      first_d    = first_q;
      acc_d      = acc_q;
      count_d    = count_q;
      err_d      = err_q;
      last_d     = last_q;
      a_d        = a_q;
      b_d        = b_q;
      tmr_clear  = 1'b0;
      tmr_enable = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               if (first_q) begin
                  acc_d   = in_data;
                  count_d = 8'd1;
                  first_d = 1'b0;
                  if (in_last) state_d = ST_OUTPUT;
               end else begin
                  a_d     = acc_q;
                  b_d     = in_data;
                  last_d  = in_last;
                  count_d = sat_inc8(count_q);
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: state_d = ST_GUARD;
         // add_done still shows the previous result here, so it is not sampled.
         ST_GUARD: begin
            tmr_clear = 1'b1;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            tmr_enable = 1'b1;
            if (add_done) begin
               acc_d   = add_sum;
               state_d = last_q ? ST_OUTPUT : ST_IDLE;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               acc_d   = '0;
               state_d = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            if (out_ready) begin
               count_d = '0;
               err_d   = 1'b0;
               first_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         first_q <= 1'b1;
         acc_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         err_q   <= err_d;
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fpacc_seq.sv
`default_nettype none
// ============================================================================
// tb_fpacc_seq
// Randomized groups against an integer-valued FP32 reference; adder model here.
// ============================================================================
module tb_fpacc_seq;
   import fp_pkg::*;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;
   logic [31:0] add_sum = '0;
   logic        add_done = 1'b0;
   logic        in_ready, add_start, out_valid, out_err;
   logic [31:0] add_a, add_b, out_data;
   logic [7:0]  out_count;

   always #5 clk = ~clk;

   fpacc_seq #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .add_start(add_start),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_done(add_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_err(out_err)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  c;
      logic        e;
   } exp_t;
   exp_t exp_q[$];

   int gvals[300];
   bit bp_hold = 1'b0;
   int start_cnt = 0;

   // Operands are small non-negative integers, so FP32 values are exact.
   function automatic logic [31:0] int2fp(input int v);
      logic [31:0] r;
      int e;
      if (v == 0) return 32'h0;
      e = 0;
      while ((v >> (e + 1)) != 0) e++;
      r[31]    = 1'b0;
      r[30:23] = 8'(127 + e);
      r[22:0]  = 23'((v << (23 - e)) & 32'h007F_FFFF);
      return r;
   endfunction

   function automatic int fp2int(input logic [31:0] f);
      int e;
      if (f[30:0] == 31'h0) return 0;
      e = int'(f[30:23]) - 127;
      return int'({1'b1, f[22:0]}) >> (23 - e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      failures++;
      $display("FAIL %s: bound expired, expected event did not occur", name);
   endtask

   // External adder: latency lat_cfg, done sticky, stale done visible one cycle past start.
   int          lat_cfg = 1;
   bit          never_done = 1'b0;
   logic [31:0] ad_a = '0, ad_b = '0;
   int          ad_cnt = 0;
   bit          ad_busy = 1'b0, ad_clr = 1'b0;

   always @(posedge clk) begin
      if (add_start) begin
         ad_a    <= add_a;
         ad_b    <= add_b;
         ad_busy <= 1'b1;
         ad_cnt  <= lat_cfg;
         ad_clr  <= 1'b1;
      end else begin
         if (ad_clr) begin
            add_done <= 1'b0;
            ad_clr   <= 1'b0;
         end
         if (ad_busy) begin
            if (ad_cnt <= 1) begin
               ad_busy <= 1'b0;
               if (!never_done) begin
                  add_done <= 1'b1;
                  add_sum  <= int2fp(fp2int(ad_a) + fp2int(ad_b));
               end
            end else begin
               ad_cnt <= ad_cnt - 1;
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // Single compare process: adder protocol and group results against the model queue.
   initial begin
      bit          prev_start = 1'b0;
      bit          hold_chk = 1'b0;
      logic [31:0] hold_a = '0, hold_b = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_start = 1'b0;
            hold_chk   = 1'b0;
         end else begin
            if (add_start) begin
               start_cnt++;
               chk("add_start_single_cycle", 32'(prev_start), 32'h0);
               hold_a   = add_a;
               hold_b   = add_b;
               hold_chk = 1'b1;
            end else if (hold_chk) begin
               chk("add_a_stable", add_a, hold_a);
               chk("add_b_stable", add_b, hold_b);
               if (add_done && !ad_busy && !ad_clr) hold_chk = 1'b0;
            end
            prev_start = add_start;
            if (out_valid) begin
               chk("in_ready_low_in_output", 32'(in_ready), 32'h0);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_out_valid: got out_data=0x%08h expected no output", out_data);
               end else begin
                  chk("out_data", out_data, exp_q[0].d);
                  chk("out_count", 32'(out_count), 32'(exp_q[0].c));
                  chk("out_err", 32'(out_err), 32'(exp_q[0].e));
                  if (out_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic send_op(input logic [31:0] d, input logic last);
      bit rdy;
      int t;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      t = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!rdy && t < 500);
      if (!rdy) fail_bound("operand_accept");
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         fail_bound("result_drain");
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // lat 0 means the adder never completes; lat > TO also forces a timeout.
   task automatic run_group(input int n, input int lat, input bit expect_out);
      int   sum, nsend;
      bit   to;
      exp_t e;
      lat_cfg    = (lat == 0) ? 1 : lat;
      never_done = (lat == 0);
      to    = (n >= 2) && (lat == 0 || lat > TO);
      nsend = to ? 2 : n;
      sum = 0;
      for (int i = 0; i < nsend; i++) sum += gvals[i];
      e.d = to ? 32'h0 : int2fp(sum);
      e.c = 8'((nsend > 255) ? 255 : nsend);
      e.e = to;
      if (expect_out) exp_q.push_back(e);
      for (int i = 0; i < nsend; i++) send_op(int2fp(gvals[i]), i == nsend - 1);
   endtask

   initial begin
      int   s0, k, n, lat, r;
      exp_t e;

      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_add_start", 32'(add_start), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_count", 32'(out_count), 32'h0);
      chk("rst_out_err", 32'(out_err), 32'h0);
      chk("rst_add_a", add_a, 32'h0);
      chk("rst_add_b", add_b, 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("in_ready_after_reset", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;

      // Single operand with last: passes straight through, no adder use.
      s0 = start_cnt;
      lat_cfg = 3; never_done = 1'b0;
      e.d = 32'h3F80_0000; e.c = 8'd1; e.e = 1'b0;
      exp_q.push_back(e);
      send_op(POS_ONE, 1'b1);
      wait_drain();
      chk("single_op_start_pulses", 32'(start_cnt - s0), 32'h0);

      // 1.0 + 2.0 + 3.0 = 6.0 with two adds.
      s0 = start_cnt;
      e.d = 32'h40C0_0000; e.c = 8'd3; e.e = 1'b0;
      exp_q.push_back(e);
      send_op(POS_ONE, 1'b0);
      send_op(POS_TWO, 1'b0);
      send_op(POS_THREE, 1'b1);
      wait_drain();
      chk("three_op_start_pulses", 32'(start_cnt - s0), 32'h2);

      // Stale done (sum 6.0) visible in GUARD; real result 1+2=3 after 5 cycles.
      e.d = 32'h4040_0000; e.c = 8'd2; e.e = 1'b0;
      exp_q.push_back(e);
      lat_cfg = 5;
      send_op(POS_ONE, 1'b0);
      send_op(POS_TWO, 1'b1);
      wait_drain();

      // Adder never completes: error result one ISSUE + GUARD + TO WAIT cycles later.
      never_done = 1'b1;
      e.d = 32'h0; e.c = 8'd2; e.e = 1'b1;
      exp_q.push_back(e);
      send_op(int2fp(2), 1'b0);
      send_op(int2fp(3), 1'b1);
      k = 0;
      forever begin
         @(negedge clk);
         if (out_valid || k > 200) break;
         k++;
      end
      chk("timeout_latency", 32'(k), 32'(TO + 2));
      wait_drain();
      never_done = 1'b0;

      // Done on the very cycle the timer expires wins; one cycle later times out.
      gvals[0] = 2; gvals[1] = 3;
      run_group(2, TO, 1'b1);
      wait_drain();
      run_group(2, TO + 1, 1'b1);
      wait_drain();

      // Output held under backpressure.
      bp_hold = 1'b1;
      @(posedge clk);
      #1;
      gvals[0] = 7;
      run_group(1, 1, 1'b1);
      repeat (10) begin
         @(negedge clk);
         chk("bp_out_valid_held", 32'(out_valid), 32'h1);
      end
      bp_hold = 1'b0;
      wait_drain();

      // Reset during WAIT: group abandoned, late done ignored, next group correct.
      gvals[0] = 4; gvals[1] = 5;
      run_group(2, 20, 1'b0);
      repeat (6) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'h0);
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready_after", 32'(in_ready), 32'h1);
      repeat (30) @(posedge clk);
      #1;
      gvals[0] = 9; gvals[1] = 1; gvals[2] = 6;
      run_group(3, 2, 1'b1);
      wait_drain();

      // Count saturation at 255 over a 300-operand group.
      for (int i = 0; i < 300; i++) gvals[i] = 1;
      run_group(300, 1, 1'b1);
      wait_drain();

      // Randomized groups.
      for (int g = 0; g < 25; g++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) gvals[i] = $urandom_range(0, 15);
         r = $urandom_range(0, 7);
         if (r == 0) lat = 0;
         else if (r == 1) lat = $urandom_range(TO - 2, TO + 4);
         else lat = $urandom_range(1, 10);
         run_group(n, lat, 1'b1);
         wait_drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fpacc_seq.md
FPACC_SEQ -- requirements
Module: fpacc_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for add_done before aborting.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand available.
REQ-005 SHALL have port in_ready  output  1  sequencer accepts an operand this cycle.
REQ-006 SHALL have port in_data  input  32  IEEE-754 single operand.
REQ-007 SHALL have port in_last  input  1  marks the final operand of a group.
REQ-008 SHALL have port add_start  output  1  one-cycle start pulse to the adder.
REQ-009 SHALL have port add_a  output  32  adder operand a, held stable from start until done is accepted.
REQ-010 SHALL have port add_b  output  32  adder operand b, held stable from start until done is accepted.
REQ-011 SHALL have port add_sum  input  32  adder result.
REQ-012 SHALL have port add_done  input  1  adder completion; level, sticky until the next start.
REQ-013 SHALL have port out_valid  output  1  group result available.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port out_data  output  32  accumulated sum.
REQ-016 SHALL have port out_count  output  8  operands in group, saturating at 255.
REQ-017 SHALL have port out_err  output  1  group aborted by timeout.

Function
REQ-018 SHALL implement states IDLE, ISSUE, GUARD, WAIT and OUTPUT.
REQ-019 IDLE: in_ready=1. The first accepted operand of a group SHALL load acc=in_data and set count=1, with no adder start. If in_last is set, go to OUTPUT; otherwise stay in IDLE with the first-operand flag cleared.
REQ-020 IDLE, subsequent operand: on in_valid&&in_ready, SHALL latch add_a=acc, add_b=in_data and the last flag, increment count (saturating), and go to ISSUE.
REQ-021 ISSUE: add_start=1 for exactly one cycle, then go to GUARD; in_ready=0 in every state other than IDLE.
REQ-022 GUARD: SHALL ignore add_done for exactly one cycle, because a stale done from the previous add is still visible; then go to WAIT.
REQ-023 WAIT: on add_done=1, SHALL set acc=add_sum, then go to OUTPUT if last is set, else to IDLE.
REQ-024 WAIT: the timeout counter SHALL reset on entry and increment each cycle; when the count reaches TIMEOUT, SHALL set err, set acc=0 and go to OUTPUT, discarding any remaining operands of the group.
REQ-025 OUTPUT: out_valid=1 with out_data=acc, out_count=count and out_err=err held stable until out_ready.
REQ-026 OUTPUT, on out_valid&&out_ready: SHALL clear count and err, set the first-operand flag and go to IDLE; in_ready SHALL rise on the next cycle (no same-cycle bypass).
REQ-027 add_start SHALL never be asserted outside ISSUE.
REQ-028 add_a and add_b SHALL not change from ISSUE through the done-accept cycle.
REQ-029 If add_done and the timeout fire in the same cycle, add_done SHALL win: result used, err=0.
REQ-030 The design SHALL perform no floating-point arithmetic internally; all sums come from add_sum.

Reset
REQ-031 While reset=0: state=IDLE, first-operand flag=1, acc=0, count=0, err=0, timer=0; all outputs 0, except in_ready, which is 0 during reset and 1 afterwards.
REQ-032 Reset asserted mid-operation (GUARD/WAIT/OUTPUT) SHALL abandon the group with no output; a late add_done after release SHALL be ignored because the state is IDLE.

Structure
REQ-033 State encoding, the TIMEOUT default and the FP constants used by the bench SHALL live in shared package fp_pkg: POS_ONE=0x3F800000, POS_TWO=0x40000000, POS_THREE=0x40400000, POS_SIX=0x40C00000.
REQ-034 The timeout counter SHALL be a sub-module named fpacc_timer, with ports clear, enable and expired.
REQ-035 The adder SHALL be instantiated outside this block, in the bench or parent.

Verification
REQ-036 Single operand 0x3F800000 with last=1 -> out_data=0x3F800000, out_count=1, out_err=0, add_start never pulses.
REQ-037 Operands 1.0, 2.0, 3.0 (last on 3.0) with the real adder -> out_data=0x40C00000, out_count=3, exactly 2 add_start pulses.
REQ-038 Adder model holding add_done=1 stale from a prior op with a 5-cycle real latency -> the result is taken after the new completion, not the stale done.
REQ-039 Adder model that never raises done, TIMEOUT=64 -> out_err=1 and out_data=0 exactly 64 WAIT cycles after GUARD.
REQ-040 out_ready held 0 for 10 cycles -> out_valid, out_data and out_count remain stable and in_ready stays 0.
REQ-041 reset pulsed during WAIT -> no out_valid, in_ready=1 after release, and the next group is correct.
